// File: rtl/ddr_axi_burst_master.sv
// ddr_axi_burst_master: turns one-shot client commands into fixed 4-beat AXI INCR bursts, one response per command.
// Optional DDR_AXI_MST_ALIGN_CHECK_EN rejects commands whose address is not 16-byte aligned without issuing traffic.
module ddr_axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [4*DATA_W-1:0] cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [4*DATA_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   M0_AWADDR,
    output logic [3:0]          M0_AWLEN,
    output logic                M0_AWVALID,
    input  logic                M0_AWREADY,
    output logic [DATA_W-1:0]   M0_WDATA,
    output logic [3:0]          M0_WSTRB,
    output logic                M0_WLAST,
    output logic                M0_WVALID,
    input  logic                M0_WREADY,
    input  logic [1:0]          M0_BRESP,
    input  logic                M0_BVALID,
    output logic                M0_BREADY,
    output logic [ADDR_W-1:0]   M0_ARADDR,
    output logic [3:0]          M0_ARLEN,
    output logic                M0_ARVALID,
    input  logic                M0_ARREADY,
    input  logic [DATA_W-1:0]   M0_RDATA,
    input  logic [1:0]          M0_RRESP,
    input  logic                M0_RLAST,
    input  logic                M0_RVALID,
    output logic                M0_RREADY
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    state_t              state, state_n;
    logic [1:0]          cnt, cnt_n;
    logic [4*DATA_W-1:0] wbuf;
    logic                misalign;
    logic                cmd_fire, w_fire, b_fire, r_fire;

`ifdef DDR_AXI_MST_ALIGN_CHECK_EN
    assign misalign = |cmd_addr[3:0];
`else
    assign misalign = 1'b0;
`endif

    assign M0_AWLEN = 4'd3;
    assign M0_ARLEN = 4'd3;
    assign M0_WSTRB = 4'hF;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign w_fire   = M0_WVALID && M0_WREADY;
    assign b_fire   = M0_BVALID && M0_BREADY;
    assign r_fire   = M0_RVALID && M0_RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (cmd_fire) begin
                state_n = misalign ? RSP : (cmd_write ? AW : AR);
                cnt_n   = 2'd0;
            end
            AW:  state_n = M0_AWREADY ? W : AW;
            W:   if (w_fire) begin
                cnt_n   = cnt + 2'd1;
                state_n = (cnt == 2'd3) ? B : W;
            end
            B:   state_n = b_fire ? RSP : B;
            AR:  state_n = M0_ARREADY ? R : AR;
            R:   if (r_fire) begin
                cnt_n   = cnt + 2'd1;
                state_n = (cnt == 2'd3) ? RSP : R;
            end
            RSP: state_n = rsp_ready ? IDLE : RSP;
            default: state_n = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode, so it changes on the edge that enters the state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            wbuf       <= '0;
            M0_AWADDR  <= '0;
            M0_AWVALID <= 1'b0;
            M0_WDATA   <= '0;
            M0_WLAST   <= 1'b0;
            M0_WVALID  <= 1'b0;
            M0_BREADY  <= 1'b0;
            M0_ARADDR  <= '0;
            M0_ARVALID <= 1'b0;
            M0_RREADY  <= 1'b0;
        end else begin
            cmd_ready  <= state_n == IDLE;
            rsp_valid  <= state_n == RSP;
            M0_AWVALID <= state_n == AW;
            M0_WVALID  <= state_n == W;
            M0_WLAST   <= state_n == W && cnt_n == 2'd3;
            M0_BREADY  <= state_n == B;
            M0_ARVALID <= state_n == AR;
            M0_RREADY  <= state_n == R;
            if (state_n == W)
                M0_WDATA <= wbuf[DATA_W*cnt_n +: DATA_W];
            if (cmd_fire) begin
                wbuf      <= cmd_wdata;
                rsp_write <= cmd_write;
                rsp_rdata <= '0;
                rsp_err   <= misalign;
                if (cmd_write)
                    M0_AWADDR <= cmd_addr;
                else
                    M0_ARADDR <= cmd_addr;
            end
            if (b_fire)
                rsp_err <= rsp_err | (|M0_BRESP);
            if (r_fire) begin
                rsp_rdata[DATA_W*cnt +: DATA_W] <= M0_RDATA;
                rsp_err <= rsp_err | (|M0_RRESP) | (M0_RLAST != (cnt == 2'd3));
            end
        end
    end
endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// tb_ddr_axi_burst_master: directed bench acting as client and AXI slave for ddr_axi_burst_master.
module tb_ddr_axi_burst_master;
    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [31:0]  cmd_addr;
    logic [127:0] cmd_wdata;
    logic         rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [127:0] rsp_rdata;
    logic [31:0]  M0_AWADDR, M0_ARADDR, M0_WDATA, M0_RDATA;
    logic [3:0]   M0_AWLEN, M0_ARLEN, M0_WSTRB;
    logic         M0_AWVALID, M0_AWREADY, M0_WLAST, M0_WVALID, M0_WREADY;
    logic [1:0]   M0_BRESP, M0_RRESP;
    logic         M0_BVALID, M0_BREADY, M0_ARVALID, M0_ARREADY;
    logic         M0_RLAST, M0_RVALID, M0_RREADY;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] D0 = {32'h87654321, 32'h12345678, 32'hC0DECAFE, 32'hDEADBEEF};
    localparam logic [127:0] D1 = {32'h0BADF00D, 32'h55AA55AA, 32'h13572468, 32'hFADEDEAF};
    localparam logic [127:0] D2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    ddr_axi_burst_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
        .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST), .M0_WVALID(M0_WVALID),
        .M0_WREADY(M0_WREADY),
        .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
        .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID),
        .M0_RREADY(M0_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic run_write(input string tag, input logic [31:0] a, input logic [127:0] d,
                             input logic toggle, input logic [1:0] bresp, input logic exp_err);
        int k = 0;
        int n = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
        M0_AWREADY = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk({tag, " awvalid"}, M0_AWVALID, 1'b1);
        chk({tag, " awaddr"}, M0_AWADDR, a);
        chk({tag, " awlen"}, M0_AWLEN, 4'd3);
        chk({tag, " cmd_ready busy"}, cmd_ready, 1'b0);
        step();
        while (M0_WVALID && n < 20) begin
            chk({tag, " wdata"}, M0_WDATA, d[32*k +: 32]);
            chk({tag, " wlast"}, M0_WLAST, k == 3);
            M0_WREADY = toggle ? n[0] : 1'b1;
            step();
            if (M0_WREADY) k++;
            n++;
        end
        M0_WREADY = 1'b0;
        chk({tag, " beat count"}, k, 4);
        chk({tag, " bready"}, M0_BREADY, 1'b1);
        M0_BVALID = 1'b1; M0_BRESP = bresp;
        step();
        M0_BVALID = 1'b0; M0_BRESP = 2'b00;
        chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, " rsp_err"}, rsp_err, exp_err);
        chk({tag, " rsp_write"}, rsp_write, 1'b1);
        chk({tag, " rsp_rdata"}, rsp_rdata, 128'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, rsp_valid, 1'b0);
        chk({tag, " cmd_ready back"}, cmd_ready, 1'b1);
    endtask

    task automatic run_read(input string tag, input logic [31:0] a, input logic [127:0] d,
                            input logic [7:0] rresp, input logic [3:0] rlast, input logic exp_err);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        M0_ARREADY = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk({tag, " arvalid"}, M0_ARVALID, 1'b1);
        chk({tag, " araddr"}, M0_ARADDR, a);
        chk({tag, " arlen"}, M0_ARLEN, 4'd3);
        step();
        for (int i = 0; i < 4; i++) begin
            chk({tag, " rready"}, M0_RREADY, 1'b1);
            M0_RVALID = 1'b1; M0_RDATA = d[32*i +: 32];
            M0_RRESP = rresp[2*i +: 2]; M0_RLAST = rlast[i];
            step();
        end
        M0_RVALID = 1'b0; M0_RRESP = 2'b00; M0_RLAST = 1'b0;
        chk({tag, " rready drop"}, M0_RREADY, 1'b0);
        chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, " rsp_rdata"}, rsp_rdata, d);
        chk({tag, " rsp_err"}, rsp_err, exp_err);
        chk({tag, " rsp_write"}, rsp_write, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " cmd_ready back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        M0_AWREADY = 1'b0; M0_WREADY = 1'b0; M0_BRESP = 2'b00; M0_BVALID = 1'b0;
        M0_ARREADY = 1'b0; M0_RDATA = '0; M0_RRESP = 2'b00; M0_RLAST = 1'b0; M0_RVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("reset cmd_ready", cmd_ready, 1'b0);
        chk("reset awvalid", M0_AWVALID, 1'b0);
        chk("reset wvalid", M0_WVALID, 1'b0);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_rdata", rsp_rdata, 128'h0);
        chk("reset awlen", M0_AWLEN, 4'd3);
        chk("reset wstrb", M0_WSTRB, 4'hF);
        ARESETn = 1'b1;
        step();
        chk("cmd_ready after reset", cmd_ready, 1'b1);

        run_write("wr0", 32'h0, D0, 1'b0, 2'b00, 1'b0);
        run_read("rd0", 32'h0, D0, 8'h00, 4'b1000, 1'b0);
        run_write("wr1000 toggle", 32'h1000, D1, 1'b1, 2'b00, 1'b0);
        run_read("rd rresp err", 32'h1000, D1, 8'b0000_1000, 4'b1000, 1'b1);
        run_read("rd rlast err", 32'h1000, D2, 8'h00, 4'b0100, 1'b1);
        run_write("wr bresp err", 32'h2000, D2, 1'b0, 2'b10, 1'b1);

        // Reset in the middle of the write data phase.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000; cmd_wdata = D2;
        M0_AWREADY = 1'b1; M0_WREADY = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("mid wdata beat2", M0_WDATA, 32'h33333333);
        #2 ARESETn = 1'b0;
        #1;
        chk("async wvalid", M0_WVALID, 1'b0);
        chk("async wlast", M0_WLAST, 1'b0);
        chk("async cmd_ready", cmd_ready, 1'b0);
        chk("async bready", M0_BREADY, 1'b0);
        @(negedge ACLK);
        M0_WREADY = 1'b0;
        ARESETn = 1'b1;
        step();
        chk("post reset idle", cmd_ready, 1'b1);
        run_write("wr after reset", 32'h4000, D0, 1'b0, 2'b00, 1'b0);

`ifdef DDR_AXI_MST_ALIGN_CHECK_EN
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = D1;
        step();
        cmd_valid = 1'b0;
        chk("align rsp_valid", rsp_valid, 1'b1);
        chk("align rsp_err", rsp_err, 1'b1);
        chk("align rsp_rdata", rsp_rdata, 128'h0);
        chk("align no awvalid", M0_AWVALID, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("align no awvalid after", M0_AWVALID, 1'b0);
        chk("align cmd_ready", cmd_ready, 1'b1);
`else
        run_write("unaligned wr", 32'h4, D1, 1'b0, 2'b00, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr_axi_burst_master.md
# ddr_axi_burst_master

Single-channel AXI burst master that sits directly upstream of `ddr_axi_slave`. It turns one-shot write and read commands from a client into fixed 4-beat AXI INCR bursts on the slave's S0 channels. It returns one response per command: packed read data or write status. It replaces hand-driven AXI stimulus as the front end of the DDR subsystem.

## Interface
- `ADDR_W`, 32, AXI address width.
- `DATA_W`, 32, AXI data width; one burst carries 4*`DATA_W` bits.
- `ACLK  in  1`  system clock; the only clock.
- `ARESETn  in  1`  asynchronous, active-low reset.
- `cmd_valid  in  1`  command request.
- `cmd_ready  out  1`  command accept; high only in IDLE.
- `cmd_write  in  1`  1 = write burst, 0 = read burst.
- `cmd_addr  in  ADDR_W`  burst start address.
- `cmd_wdata  in  4*DATA_W`  write beats; beat0 = [DATA_W-1:0].
- `rsp_valid  out  1`  response available.
- `rsp_ready  in  1`  response accept.
- `rsp_write  out  1`  echo of `cmd_write`.
- `rsp_rdata  out  4*DATA_W`  read beats in `cmd_wdata` order; 0 for writes.
- `rsp_err  out  1`  1 when any BRESP/RRESP ≠ OKAY, an RLAST mismatch occurs, or the alignment check rejects the command.
- `M0_AWADDR/AWLEN/AWVALID/AWREADY`, `M0_WDATA/WSTRB/WLAST/WVALID/WREADY`, `M0_BRESP/BVALID/BREADY`, `M0_ARADDR/ARLEN/ARVALID/ARREADY`, `M0_RDATA/RRESP/RLAST/RVALID/RREADY`:
  - Master side of the AXI ports of `ddr_axi_slave`.
  - Widths: ADDR_W, 4, 1, 1 / DATA_W, 4, 1, 1, 1 / 2, 1, 1 / ADDR_W, 4, 1, 1 / DATA_W, 2, 1, 1, 1.

## Operation
- States and transitions:
  - IDLE → AW on a write command handshake.
  - IDLE → AR on a read command handshake.
  - AW → W → B → RSP.
  - AR → R → RSP.
  - RSP → IDLE.
- Command capture: on `cmd_valid && cmd_ready`, latch the address, data and direction, and clear the error and beat counter.
- AW state: `M0_AWVALID`=1 with `M0_AWLEN`=3, held until `M0_AWREADY`. The address and length stay stable while valid.
- W state:
  - 2-bit beat counter selects the beat; `M0_WSTRB`=4'hF.
  - `M0_WLAST`=1 on beat 3 only.
  - `M0_WVALID` stays high across beats; each `M0_WREADY` advances the counter.
  - The handshake on beat 3 → B.
- B state: `M0_BREADY`=1. On `M0_BVALID`: err |= (BRESP≠0), → RSP.
- AR state: `M0_ARVALID`=1 with `M0_ARLEN`=3 until `M0_ARREADY`.
- R state:
  - `M0_RREADY`=1; each `M0_RVALID` stores RDATA into slot[counter].
  - err |= (RRESP≠0).
  - err |= (RLAST ≠ (counter==3)).
  - After beat 3 → RSP.
- RSP state: `rsp_valid`=1 with fields held until `rsp_ready`, then → IDLE.
- Strictly one outstanding transaction; no AW/W overlap and no read/write overlap.
- `M0_BVALID` is ignored outside B and `M0_RVALID` outside R, because the matching ready is low.

## Timing
- All outputs are registered.
- Reset values:
  - All VALID/READY outputs, `cmd_ready`, `rsp_valid`, `rsp_err`, `rsp_write`, `M0_WLAST`: 0.
  - Addresses, data, `rsp_rdata`: 0.
  - `M0_AWLEN`=`M0_ARLEN`=3; `M0_WSTRB`=4'hF.
  - State = IDLE.
- `cmd_ready` rises on the first `ACLK` edge after reset release.
- Write latency with an always-ready slave:
  - Command handshake at cycle 0.
  - AWVALID at cycle 1.
  - WVALID at cycles 2–5.
  - BREADY from cycle 6.
  - If BVALID is high at cycle 6, `rsp_valid` is high at cycle 7.
- Read latency with an always-ready slave:
  - ARVALID at cycle 1.
  - RREADY from cycle 2.
  - If beats arrive at cycles 2–5, `rsp_valid` is high at cycle 6.
- Stalls: any READY/VALID low stretches the current state indefinitely. There is no timeout.
- Back-to-back commands: `cmd_ready` returns the cycle after the `rsp_valid && rsp_ready` handshake. Minimum gap is 1 idle cycle.
- Reset mid-burst: outputs go to reset values asynchronously. The in-flight command and its response are discarded.

## Configuration
- `DDR_AXI_MST_ALIGN_CHECK_EN` defined:
  - A command with `cmd_addr[3:0]`≠0 goes IDLE → RSP with `rsp_err`=1 and `rsp_rdata`=0.
  - It issues no AXI traffic.
  - Latency: `rsp_valid` at cycle 1.
- Undefined: every address is issued unchanged; alignment is the slave's concern.

## Test plan
- Write 0x0000_0000 with DEADBEEF, C0DECAFE, 12345678, 87654321; slave always ready:
  - AWADDR=0, AWLEN=3.
  - Beats appear in order; WLAST only on beat 3.
  - `rsp_valid` with `rsp_err`=0.
- Read back 0x0000_0000 → `rsp_rdata` = {87654321,12345678,C0DECAFE,DEADBEEF}, `rsp_err`=0.
- Write 0x1000 with FADEDEAF… while WREADY toggles every other cycle → no beat lost or duplicated, WDATA stable while stalled, 4 handshakes total.
- Error responses:
  - Read with RRESP=2'b10 on beat 1 → `rsp_err`=1, all 4 beats still consumed.
  - Read with RLAST on beat 2 → `rsp_err`=1.
- Reset mid-burst: assert `ARESETn`=0 during W beat 2 → all VALIDs drop immediately, `cmd_ready`=0. After release, a new write completes normally.
- With `DDR_AXI_MST_ALIGN_CHECK_EN`: command to 0x0000_0004 → no AWVALID ever, `rsp_err`=1 at cycle 1. Without the macro, the same command → AWADDR=0x4 is issued.
